buzzer_arbiter: RTL and testbench

Round-robin scheduler that shares one audible alert slot among the 8 sensor inputs of the tt_um_aditya_patra alarm design. It sits between the sensor pins (ui_in) and the buzzer pins (uo_out). Only one buzzer sounds at a time, as a square-wave tone, for a fixed dwell, followed by a silent gap. Requesters are served in rotating order so that no sensor is starved while others stay active.

---
 rtl/buzzer_arbiter.sv | 118 +++++++++++
 tb/tb_buzzer_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// Round-robin alert scheduler: grants one sensor at a time a toned buzzer slot
// of DWELL cycles followed by a silent GAP, rotating priority after each grant.
module buzzer_arbiter #(
  parameter int DWELL     = 8,
  parameter int GAP       = 2,
  parameter int TONE_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] sensor,
  output logic [7:0] buzzer,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic [7:0] events
);

  localparam logic [7:0] DwellLoad = 8'(DWELL - 1);
  localparam logic [7:0] GapLoad   = 8'(GAP - 1);
  localparam logic [7:0] ToneLoad  = 8'(TONE_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  req_q;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  timer_q, timer_d;
  logic        tone_q, tone_d;
  logic [7:0]  tone_cnt_q, tone_cnt_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [7:0]  events_q, events_d;
  logic [2:0]  winner;
  logic [2:0]  idx;

  // Descending scan so the requester closest to ptr_q is the last one written.
  always_comb begin
    winner = ptr_q;
    idx    = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (req_q[idx]) winner = idx;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    tone_d     = tone_q;
    tone_cnt_d = tone_cnt_q;
    grant_id_d = grant_id_q;
    events_d   = events_q;
    case (state_q)
      S_IDLE: begin
        if (ena && (req_q != 8'd0)) begin
          grant_id_d = winner;
          ptr_d      = winner + 3'd1;
          timer_d    = DwellLoad;
          tone_d     = 1'b1;
          tone_cnt_d = ToneLoad;
          events_d   = events_q + 8'd1;
          state_d    = S_ON;
        end
      end
      S_ON: begin
        if (tone_cnt_q == 8'd0) begin
          tone_d     = ~tone_q;
          tone_cnt_d = ToneLoad;
        end else begin
          tone_cnt_d = tone_cnt_q - 8'd1;
        end
        if (timer_q == 8'd0) begin
          timer_d = GapLoad;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_GAP: begin
        if (timer_q == 8'd0) state_d = S_IDLE;
        else timer_d = timer_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 8'd0;
      ptr_q      <= 3'd0;
      timer_q    <= 8'd0;
      tone_q     <= 1'b0;
      tone_cnt_q <= 8'd0;
      grant_id_q <= 3'd0;
      events_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= sensor;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      tone_q     <= tone_d;
      tone_cnt_q <= tone_cnt_d;
      grant_id_q <= grant_id_d;
      events_q   <= events_d;
    end
  end

  assign grant_valid = (state_q == S_ON);
  assign buzzer      = (grant_valid && tone_q) ? (8'd1 << grant_id_q) : 8'd0;
  assign grant_id    = grant_id_q;
  assign events      = events_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Bench for buzzer_arbiter: a grant-timeline model is checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_buzzer_arbiter;

  localparam int DWELL     = 8;
  localparam int GAP       = 2;
  localparam int TONE_HALF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] sensor;
  logic [7:0] buzzer;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [7:0] events;

  int total = 0;
  int bad   = 0;

  buzzer_arbiter #(.DWELL(DWELL), .GAP(GAP), .TONE_HALF(TONE_HALF)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .sensor(sensor),
    .buzzer(buzzer),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .events(events)
  );

  always #5 clk = ~clk;

  // Model: a grant is remembered by the edge it started on; everything the
  // outputs show follows from how many edges have passed since then.
  int         cyc     = 0;
  int         mStart  = 0;
  bit         mBusy   = 0;
  logic [7:0] mReq    = 8'd0;
  int         mPtr    = 0;
  int         mId     = 0;
  int         mEvents = 0;

  always @(posedge clk) begin
    bit idleBefore;
    cyc++;
    if (rst) begin
      mReq = 8'd0; mPtr = 0; mBusy = 0; mId = 0; mEvents = 0;
    end else begin
      idleBefore = !mBusy || ((cyc - 1 - mStart) >= DWELL + GAP);
      if (idleBefore && ena && (mReq != 8'd0)) begin
        for (int i = 0; i < 8; i++) begin
          if (mReq[(mPtr + i) % 8]) begin
            mId = (mPtr + i) % 8;
            break;
          end
        end
        mPtr    = (mId + 1) % 8;
        mStart  = cyc;
        mBusy   = 1;
        mEvents = (mEvents + 1) % 256;
      end
      mReq = sensor;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (time %0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    int   phase;
    bit   gvExp;
    logic [7:0] buzExp;
    if (cyc > 0) begin
      phase  = cyc - mStart;
      gvExp  = mBusy && (phase < DWELL);
      buzExp = (gvExp && ((phase / TONE_HALF) % 2 == 0)) ? (8'd1 << mId) : 8'd0;
      checkOutput("model_grant_valid", int'(grant_valid), int'(gvExp));
      checkOutput("model_buzzer", int'(buzzer), int'(buzExp));
      checkOutput("model_grant_id", int'(grant_id), mId);
      checkOutput("model_events", int'(events), mEvents);
      checkOutput("onehot_buzzer", int'($countones(buzzer) <= 1), 1);
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] s);
    rst    = r;
    ena    = e;
    sensor = s;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pat[11] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b1, 8'hFF);
    step(2);
    checkOutput("reset_buzzer", int'(buzzer), 0);
    checkOutput("reset_valid", int'(grant_valid), 0);
    checkOutput("reset_id", int'(grant_id), 0);
    checkOutput("reset_events", int'(events), 0);

    // All sensors held: ids rotate 0..7 then wrap, 11 cycles apart.
    applyStimulus(1'b0, 1'b1, 8'hFF);
    step(2);
    checkOutput("first_grant_id", int'(grant_id), 0);
    checkOutput("first_grant_buzzer", int'(buzzer), 8'h01);
    checkOutput("first_grant_events", int'(events), 1);
    step(77);
    checkOutput("eighth_grant_id", int'(grant_id), 7);
    checkOutput("eighth_grant_events", int'(events), 8);
    step(10);
    checkOutput("eighth_idle_valid", int'(grant_valid), 0);
    checkOutput("eighth_idle_events", int'(events), 8);
    step(1);
    checkOutput("wrap_grant_id", int'(grant_id), 0);
    checkOutput("wrap_grant_events", int'(events), 9);

    // Single sensor: tone and dwell/gap pattern over two full periods.
    applyStimulus(1'b1, 1'b1, 8'h01);
    step(2);
    applyStimulus(1'b0, 1'b1, 8'h01);
    step(2);
    for (int i = 0; i < 22; i++) begin
      checkOutput("tone_pattern", int'(buzzer), pat[i % 11] ? 8'h01 : 8'h00);
      checkOutput("tone_events", int'(events), 1 + i / 11);
      step(1);
    end

    // Two sensors alternate.
    applyStimulus(1'b1, 1'b1, 8'h06);
    step(2);
    applyStimulus(1'b0, 1'b1, 8'h06);
    step(2);
    for (int g = 0; g < 4; g++) begin
      checkOutput("alternate_id", int'(grant_id), (g % 2 == 1) ? 2 : 1);
      checkOutput("alternate_valid", int'(grant_valid), 1);
      step(11);
    end

    // One-cycle pulse, then enable gating.
    applyStimulus(1'b1, 1'b1, 8'h00);
    step(2);
    applyStimulus(1'b0, 1'b1, 8'h04);
    step(1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    step(1);
    checkOutput("pulse_buzzer", int'(buzzer), 8'h04);
    checkOutput("pulse_events", int'(events), 1);
    step(15);
    checkOutput("pulse_idle_valid", int'(grant_valid), 0);
    checkOutput("pulse_idle_events", int'(events), 1);
    applyStimulus(1'b0, 1'b0, 8'h10);
    step(5);
    checkOutput("ena_low_valid", int'(grant_valid), 0);
    checkOutput("ena_low_events", int'(events), 1);
    applyStimulus(1'b0, 1'b1, 8'h10);
    step(1);
    checkOutput("ena_high_buzzer", int'(buzzer), 8'h10);
    checkOutput("ena_high_id", int'(grant_id), 4);
    applyStimulus(1'b0, 1'b1, 8'h00);
    step(12);

    // Reset in the middle of a grant.
    applyStimulus(1'b1, 1'b1, 8'h08);
    step(2);
    applyStimulus(1'b0, 1'b1, 8'h08);
    step(2);
    checkOutput("pre_reset_buzzer", int'(buzzer), 8'h08);
    step(2);
    applyStimulus(1'b1, 1'b1, 8'h08);
    step(1);
    checkOutput("mid_reset_buzzer", int'(buzzer), 0);
    checkOutput("mid_reset_valid", int'(grant_valid), 0);
    checkOutput("mid_reset_events", int'(events), 0);
    applyStimulus(1'b0, 1'b1, 8'h08);
    step(2);
    checkOutput("regrant_buzzer", int'(buzzer), 8'h08);
    checkOutput("regrant_id", int'(grant_id), 3);
    checkOutput("regrant_events", int'(events), 1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    step(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
